// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one synchronous RAM among NCORES cores,
// with registered RAM controls, tagged read returns and an optional grant quantum.
module mem_arbiter_rr #(
    parameter int NCORES  = 3,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1,
    parameter int QUANTUM = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    rden,
    input  logic [NCORES-1:0]    wren,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] din,
    input  logic [DW-1:0]        ram_q,
    output logic [NCORES-1:0]    acq,
    output logic [NCORES*DW-1:0] dq,
    output logic [NCORES-1:0]    rvalid,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren
);
    localparam int IW = $clog2(NCORES);
    localparam int CW = QUANTUM > 0 ? $clog2(QUANTUM + 1) : 1;
    typedef enum logic {IDLE, OWN} state_t;
    state_t state, state_n;
    logic [IW-1:0] owner, owner_n, ptr, ptr_n, pend_w, pend_w_n, win, j;
    logic [CW-1:0] cnt, cnt_n;
    logic [NCORES-1:0] req;
    logic [RD_LAT:0] tv;
    logic [RD_LAT:0][IW-1:0] tw;
    logic pend, pend_n, found, acc, last, hand;
    assign req  = rden | wren;
    assign acc  = state == OWN && req[owner];
    assign last = QUANTUM > 0 && cnt == CW'(QUANTUM - 1);
    assign hand = state == OWN && (!req[owner] || (last && found));
    assign acq  = state == OWN ? NCORES'(1) << owner : '0;
    // While owning, the scan skips the owner itself (offset NCORES wraps back to ptr == owner).
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = '0;
        for (int k = NCORES; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % NCORES);
            if (req[j] && !(state == OWN && k == NCORES)) begin
                found = 1'b1;
                win   = j;
            end
        end
    end
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        cnt_n    = cnt;
        pend_n   = pend;
        pend_w_n = pend_w;
        if (state == IDLE) begin
            if (pend || found) begin
                state_n = OWN;
                owner_n = pend ? pend_w : win;
                ptr_n   = pend ? pend_w : win;
                cnt_n   = '0;
                pend_n  = 1'b0;
            end
        end else if (hand) begin
            state_n  = IDLE;
            pend_n   = found;
            pend_w_n = win;
        end else if (acc && !last) begin
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= IW'(NCORES - 1);
            cnt      <= '0;
            pend     <= 1'b0;
            pend_w   <= '0;
            tv       <= '0;
            tw       <= '0;
            dq       <= '0;
            rvalid   <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            pend     <= pend_n;
            pend_w   <= pend_w_n;
            tv       <= {tv[RD_LAT-1:0], acc && !wren[owner]};
            tw       <= {tw[RD_LAT-1:0], owner};
            rvalid   <= tv[RD_LAT] ? NCORES'(1) << tw[RD_LAT] : '0;
            ram_wren <= acc && wren[owner];
            if (tv[RD_LAT])
                dq[tw[RD_LAT]*DW +: DW] <= ram_q;
            if (acc) begin
                ram_addr <= addr[owner*AW +: AW];
                ram_din  <= din[owner*DW +: DW];
            end
        end
    end
endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised round-robin arbiter that lets NCORES processor cores share one single-port synchronous data RAM. It grants exclusive ownership to one core at a time and forwards that core's address, data and write enable to the RAM through registers. It returns read data to the issuing core with a valid pulse. A configurable quantum bounds how long one core can hold the RAM while others wait. It sits between the core array and the shared data RAM, replacing the fixed three-core byte-wide controller.

## Interface
- NCORES, 3, number of requesting cores (2..16)
- AW, 8, RAM address width
- DW, 8, RAM data width
- RD_LAT, 1, RAM read latency in clocks (1..4)
- QUANTUM, 8, max accesses per grant while another core waits; 0 = unlimited
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rden  in  NCORES  per-core read request, held until served/released
- wren  in  NCORES  per-core write request
- addr  in  NCORES*AW  per-core address, slice i = [i*AW +: AW]
- din  in  NCORES*DW  per-core write data, slice i = [i*DW +: DW]
- ram_q  in  DW  RAM read data
- acq  out  NCORES  grant, one-hot or zero
- dq  out  NCORES*DW  per-core read data, slice i holds last read for core i
- rvalid  out  NCORES  one-cycle read-data-valid per core
- ram_addr  out  AW  registered RAM address
- ram_din  out  DW  registered RAM write data
- ram_wren  out  1  registered RAM write enable

## Operation
- Reset (async, rst=1): acq=0, dq=0, rvalid=0, ram_addr=0, ram_din=0, ram_wren=0, state IDLE, rr pointer=NCORES-1 (core 0 wins first), quantum counter=0, read-tag pipeline cleared. No rvalid may appear from accesses issued before reset.
- req[i] = rden[i] | wren[i].
- States: IDLE, OWN.
- IDLE: if any req, winner = first requesting core scanning pointer+1, pointer+2, … modulo NCORES. Next edge sets acq[winner]=1, owner=winner, pointer=winner, counter=0, state OWN. If no req, stay IDLE.
- OWN, owner w, acq[w]=1. Each edge where req[w]=1 is one access.
  - ram_addr <= addr slice w; ram_din <= din slice w; ram_wren <= wren[w].
  - rden and wren both high: write wins, no read tag.
  - A pure read pushes tag (valid, w) into an RD_LAT+1 deep pipeline. Counter increments.
- Release: edge in OWN with req[w]=0. ram_wren <= 0, acq[w] <= 0. Re-arbitrate in the same edge from pointer=w, excluding w. If there is a winner, its acq rises in the cycle after release, giving one dead cycle with acq=0. Otherwise go to IDLE.
- Forced rotation: QUANTUM>0, the access being accepted is the QUANTUM-th of this grant, and another core requests. That access completes; at the same edge acq[w] <= 0 and the handoff proceeds as in Release. Core w keeps its request and is served again in rotation.
- Read return: when the tag leaves the pipeline, dq slice tag.owner <= ram_q and rvalid[tag.owner] <= 1 for one cycle. Returns are tagged, so they complete correctly after the owner has changed.
- Other dq slices hold their value. ram_addr and ram_din hold their last value when idle.

## Timing
- Grant latency from IDLE: req rises before edge E0; acq high after E0. First access is sampled at E1.
- Access sampled at edge En: ram_addr/ram_wren valid after En. RAM data is valid RD_LAT cycles later. dq/rvalid are registered at En+RD_LAT+1.
- Throughput: one access per cycle for the owner. Handoff costs one dead cycle.
- A write is visible to a read from any core issued at a later edge.
- Cores must present addr/din in the same cycle as the request while acq is high. Changing them while acq=0 has no effect.

## Test plan
- Single read: after reset, core1 rden=1, addr=0x05, RAM[5]=0xA7, RD_LAT=1. Required: acq=3'b010 after E0; ram_addr=0x05 after E1; dq[15:8]=0xA7 and rvalid=3'b010 for one cycle after E3.
- Write then read: core0 writes 0x3C to 0x10 (one cycle), then reads 0x10 in the next cycle. Required: ram_wren pulses once; read returns 0x3C.
- Round-robin: all three cores request from reset and release after one access each. Required: grant order 0,1,2,0; one acq=0 cycle between grants; acq never has more than one bit set.
- Quantum: QUANTUM=4, core0 streams reads of 0x00..0x07, core2 requests from cycle 2. Required: core0 gets exactly 4 accesses, then core2 is granted; core0 resumes at 0x04 afterwards. All 8 rvalid pulses go to core0 with correct data.
- Simultaneous rden+wren: core1 both high with din=0x55. Required: write performed, no rvalid.
- Reset mid-read: assert rst one cycle after a read is sampled. Required: all outputs 0 immediately; no rvalid after rst deasserts; next grant goes to core 0.
